render_reg_arbiter: RTL
=======================

# render_reg_arbiter

Two-port arbiter and AXI4-Lite master sequencer for the render_register bank, which has four 32-bit registers at byte offsets 0x0–0xC. It accepts single-word read/write commands from two on-chip requesters (port 0: host config path, port 1: render engine) and grants them round-robin. Each granted command becomes exactly one AXI4-Lite transaction on the master port. The response data and status are then returned to the requester that issued the command.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4, master address width; covers the register bank.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  reset, asynchronous, active-low.
- reqN_valid  in  1  (N=0,1) command pending; held until reqN_ready.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  C_M_AXI_ADDR_WIDTH  byte address; bits [1:0] ignored and forced to 0 on the bus.
- reqN_wdata  in  32  write data.
- reqN_ready  out  1  command accepted this cycle (combinational).
- reqN_done  out  1  one-cycle pulse: transaction complete.
- reqN_rdata  out  32  read data; valid while reqN_done is high, held afterwards.
- reqN_resp  out  2  BRESP/RRESP of the completed transaction; valid with reqN_done.
- err_count  out  16  saturating count of non-OKAY responses.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. AWPROT and ARPROT are 3'b000. WSTRB is 4'hF.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE grant rules:
  - Only one valid requester: grant it.
  - Both valid: grant the port not in last_grant.
  - Granted port sees reqN_ready=1 for that cycle. At the edge the arbiter latches addr/we/wdata, records the owner, updates last_grant, and moves to WR_REQ or RD_REQ.
  - reqN_ready is 0 in every state other than IDLE.
- WR_REQ:
  - AWVALID and WVALID rise together on entry.
  - Each drops independently after its own handshake (AWVALID&AWREADY, WVALID&WREADY); the two handshakes may land in either order or in the same cycle.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, pulse owner's done next cycle, return to IDLE.
- RD_REQ: ARVALID=1 until ARREADY, then RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP into the owner's rdata/resp, pulse done, return to IDLE.
- Response routing: the non-owner's rdata/resp/done are unchanged.
- err_count increments by 1 on each B or R handshake with resp != 2'b00. It saturates at 0xFFFF.
- Valid signals are never withdrawn before their handshake; address and data stay stable while valid is high.

## Timing
- Reset (ARESETN low, asynchronous):
  - State IDLE.
  - All AXI valid and ready outputs 0; AWADDR/ARADDR/WDATA 0.
  - reqN_done 0, reqN_rdata 0, reqN_resp 0, err_count 0.
  - last_grant=1, so port 0 wins the first tie.
- Reset mid-transaction: the transaction is abandoned, with no done pulse. The slave is reset in the same domain.
- Latency with zero-wait slave:
  - Accept at cycle 0; AWVALID/WVALID (or ARVALID) registered high at cycle 1.
  - BVALID/RVALID at cycle 2.
  - reqN_done at cycle 3.
  - Next accept possible in cycle 3 (IDLE concurrent with done).
- Throughput: 3 cycles per transaction minimum; each ready stall adds 1 cycle.
- A requester may hold valid through its own done and be re-granted only if the other port is idle.
- reqN_ready never asserts for both ports in the same cycle.

## Test plan
- Four sequential writes from port 0: 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then four reads. Required: rdata 0x1–0x4, resp 00, err_count 0, done 3 cycles after each accept.
- Write with AWREADY delayed 4 cycles and WREADY immediate, and again with the delays swapped. Required: each valid drops right after its own handshake, exactly one B is accepted, done is asserted once.
- Both ports hold valid continuously, port 0 writing 0xAAAA0000 and port 1 writing 0x5555FFFF, both to addr 0x8, for 6 commands. Required: grants alternate 0,1,0,1,0,1, and a final read returns 0x5555FFFF.
- Slave returns SLVERR (2'b10) on one read. Required: that port's resp=10, other port unaffected, err_count=1.
- Address 0x7 issued as a write. Required: AWADDR=0x4.
- Assert ARESETN low while in WR_RESP. Required: all outputs return to reset values asynchronously, and no done pulse. A new read of 0x0 after release completes normally.

Source files
------------

// File: rtl/render_reg_arbiter.sv
// ---------------------------------------------------------------------------
// render_reg_arbiter
//
// Two-port round-robin arbiter in front of an AXI4-Lite master that talks to
// the four-register render_register bank (byte offsets 0x0..0xC). Each
// accepted command becomes exactly one AXI4-Lite transaction. Its response
// (data and status) goes back to the port that issued it.
//
// Ports
//   ACLK, ARESETN          clock; asynchronous active-low reset
//   reqN_valid/we/addr/wdata   command from requester N (0 = host config,
//                              1 = render engine)
//   reqN_ready             command accepted this cycle (combinational)
//   reqN_done              one-cycle completion pulse
//   reqN_rdata/reqN_resp   read data / BRESP-RRESP of the last completed
//                          transaction of port N (held until the next one)
//   err_count              saturating count of non-OKAY responses
//   dbg_state              current FSM state, for observation only
//   M_AXI_*                AXI4-Lite master channels
//
// Handshake rule used on every channel here: a transfer happens on a rising
// edge where valid and ready are both high. Once valid is raised it stays
// high, with its address/data stable, until that transfer. Ready may depend
// combinationally on state but never on the partner's ready.
// ---------------------------------------------------------------------------
module render_reg_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic                            req0_valid,
    input  logic                            req0_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
    output logic                            req0_ready,
    output logic                            req0_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
    output logic [1:0]                      req0_resp,

    input  logic                            req1_valid,
    input  logic                            req1_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
    output logic                            req1_ready,
    output logic                            req1_done,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
    output logic [1:0]                      req1_resp,

    output logic [15:0]                     err_count,
    output logic [2:0]                      dbg_state,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    logic [2:0] state;
    logic       last_grant;   // port granted most recently
    logic       owner;        // port owning the transaction in flight

    logic       gnt0;
    logic       gnt1;
    logic       sel_we;
    logic [C_M_AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] sel_wdata;
    logic       aw_pending_next;
    logic       w_pending_next;
    logic       b_hs;
    logic       r_hs;
    logic       bad_resp;

    // Word alignment: the byte-lane bits of the request address are dropped.
    logic       addr_lsb_unused;
    assign addr_lsb_unused = ^{req0_addr[1:0], req1_addr[1:0]};

    // Round robin: on a tie the port that did not win last time gets the bus.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_IDLE) begin
            if (req0_valid && (!req1_valid || last_grant))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign sel_we    = gnt1 ? req1_we    : req0_we;
    assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
    assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

    // AW and W complete independently; each valid falls after its own transfer.
    assign aw_pending_next = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_pending_next  = M_AXI_WVALID  && !M_AXI_WREADY;

    assign b_hs     = (state == ST_WR_RESP) && M_AXI_BVALID;
    assign r_hs     = (state == ST_RD_RESP) && M_AXI_RVALID;
    assign bad_resp = (b_hs && (M_AXI_BRESP != 2'b00)) ||
                      (r_hs && (M_AXI_RRESP != 2'b00));

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_BREADY = (state == ST_WR_RESP);
    assign M_AXI_RREADY = (state == ST_RD_RESP);
    assign dbg_state    = state;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            req0_done     <= 1'b0;
            req0_rdata    <= '0;
            req0_resp     <= 2'b00;
            req1_done     <= 1'b0;
            req1_rdata    <= '0;
            req1_resp     <= 2'b00;
            err_count     <= 16'd0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;

            if (bad_resp && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        if (sel_we) begin
                            M_AXI_AWADDR  <= {sel_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
                            M_AXI_WDATA   <= sel_wdata;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            M_AXI_ARADDR  <= {sel_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    M_AXI_AWVALID <= aw_pending_next;
                    M_AXI_WVALID  <= w_pending_next;
                    if (!aw_pending_next && !w_pending_next)
                        state <= ST_WR_RESP;
                end

                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        if (owner) begin
                            req1_resp <= M_AXI_BRESP;
                            req1_done <= 1'b1;
                        end else begin
                            req0_resp <= M_AXI_BRESP;
                            req0_done <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        state         <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        if (owner) begin
                            req1_rdata <= M_AXI_RDATA;
                            req1_resp  <= M_AXI_RRESP;
                            req1_done  <= 1'b1;
                        end else begin
                            req0_rdata <= M_AXI_RDATA;
                            req0_resp  <= M_AXI_RRESP;
                            req0_done  <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
